// File: rtl/bit_scan_seq.sv
// rtl/bit_scan_seq.sv - scans a captured vector and emits one beat per set bit
module bit_scan_seq #(
  parameter int WIDTH = 8,
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_empty
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_EMPTY = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q;
  logic             mode_q;
  logic             out_valid_q;
  logic [IDXW-1:0]  out_idx_q;
  logic             out_last_q;
  logic             out_empty_q;

  // rem_q always includes the bit currently on out_idx; rem_d drops it
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] scan_vec;
  logic             scan_msb;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_single;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_empty = out_empty_q;

  // Select the vector whose next beat is being prepared and find its next set bit
  always_comb begin
    rem_d = rem_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (IDXW'(i) == out_idx_q) rem_d[i] = 1'b0;
    end

    scan_vec = (state_q == S_IDLE) ? in_data : rem_d;
    scan_msb = (state_q == S_IDLE) ? in_msb_first : mode_q;

    pick_idx = '0;
    if (scan_msb) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (scan_vec[i]) pick_idx = IDXW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (scan_vec[i]) pick_idx = IDXW'(i);
      end
    end

    pick_single = (scan_vec != '0) && ((scan_vec & (scan_vec - WIDTH'(1))) == '0);
  end

  // Control FSM with registered beat outputs, advanced on each accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            rem_q       <= in_data;
            mode_q      <= in_msb_first;
            out_valid_q <= 1'b1;
            if (in_data != '0) begin
              state_q     <= S_SCAN;
              out_idx_q   <= pick_idx;
              out_last_q  <= pick_single;
              out_empty_q <= 1'b0;
            end else begin
              state_q     <= S_EMPTY;
              out_idx_q   <= '0;
              out_last_q  <= 1'b1;
              out_empty_q <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (out_ready) begin
            rem_q <= rem_d;
            if (out_last_q) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_idx_q  <= pick_idx;
              out_last_q <= pick_single;
            end
          end
        end
        S_EMPTY: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_empty_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_scan_seq.sv
// tb/tb_bit_scan_seq.sv - self-checking bench for bit_scan_seq
module tb_bit_scan_seq;

  localparam int WIDTH = 8;
  localparam int IDXW  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_msb_first = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_empty;

  typedef struct {
    int idx;
    bit last;
    bit empty;
  } beat_t;

  beat_t mq[$];
  beat_t log_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  bit_scan_seq #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .out_empty    (out_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats of a vector: its set bits in scan order, last on the final one
  function automatic void model_push(input logic [WIDTH-1:0] d, input logic msb);
    beat_t b;
    if (d == '0) begin
      b.idx = 0; b.last = 1'b1; b.empty = 1'b1;
      mq.push_back(b);
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        int i;
        i = msb ? (WIDTH - 1 - k) : k;
        if (d[i]) begin
          b.idx = i; b.last = 1'b0; b.empty = 1'b0;
          mq.push_back(b);
        end
      end
      mq[mq.size()-1].last = 1'b1;
    end
  endfunction

  // Compare every cycle, then apply the effects of the coming clock edge to the model
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && mq.size() == 0)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
    if (out_valid && mq.size() != 0) begin
      chk("out_idx", {29'd0, out_idx}, mq[0].idx);
      chk("out_last", {31'd0, out_last}, {31'd0, mq[0].last});
      chk("out_empty", {31'd0, out_empty}, {31'd0, mq[0].empty});
    end
    if (rst) begin
      mq.delete();
    end else if (mq.size() != 0) begin
      if (out_ready) begin
        beat_t b;
        b.idx = int'(out_idx); b.last = out_last; b.empty = out_empty;
        log_q.push_back(b);
        void'(mq.pop_front());
      end
    end else if (in_valid) begin
      model_push(in_data, in_msb_first);
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 60 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic msb);
    wait_ready();
    in_valid = 1'b1; in_data = d; in_msb_first = msb;
    @(posedge clk); #1;
    in_valid = 1'b0; in_msb_first = ~msb; in_data = 8'h5A;
  endtask

  task automatic run(input logic [WIDTH-1:0] d, input logic msb);
    log_q.delete();
    send(d, msb);
    wait_ready();
  endtask

  task automatic chk_log(input string name, input int pos, input int idx, input bit last, input bit empty);
    if (pos >= log_q.size()) begin
      chk({name, "_missing"}, pos, log_q.size());
    end else begin
      chk({name, "_idx"}, log_q[pos].idx, idx);
      chk({name, "_last"}, {31'd0, log_q[pos].last}, {31'd0, last});
      chk({name, "_empty"}, {31'd0, log_q[pos].empty}, {31'd0, empty});
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_idx", {29'd0, out_idx}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_empty", {31'd0, out_empty}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // single bit, one cycle latency
    log_q.delete();
    send(8'h01, 1'b0);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_idx", {29'd0, out_idx}, 32'd0);
    chk("single_last", {31'd0, out_last}, 32'd1);
    chk("single_empty", {31'd0, out_empty}, 32'd0);
    wait_ready();
    chk("single_count", log_q.size(), 32'd1);

    // multiple bits, both orders
    run(8'b1010_0100, 1'b0);
    chk("a4_lsb_count", log_q.size(), 32'd3);
    chk_log("a4_lsb0", 0, 2, 1'b0, 1'b0);
    chk_log("a4_lsb1", 1, 5, 1'b0, 1'b0);
    chk_log("a4_lsb2", 2, 7, 1'b1, 1'b0);
    run(8'b1010_0100, 1'b1);
    chk("a4_msb_count", log_q.size(), 32'd3);
    chk_log("a4_msb0", 0, 7, 1'b0, 1'b0);
    chk_log("a4_msb1", 1, 5, 1'b0, 1'b0);
    chk_log("a4_msb2", 2, 2, 1'b1, 1'b0);

    // zero vector
    log_q.delete();
    send(8'h00, 1'b0);
    chk("zero_valid", {31'd0, out_valid}, 32'd1);
    chk("zero_idx", {29'd0, out_idx}, 32'd0);
    chk("zero_last", {31'd0, out_last}, 32'd1);
    chk("zero_empty", {31'd0, out_empty}, 32'd1);
    @(posedge clk); #1;
    chk("zero_ready_back", {31'd0, in_ready}, 32'd1);

    // back-pressure on idx 5
    log_q.delete();
    send(8'hFF, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_idx_before", {29'd0, out_idx}, 32'd5);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_stall_idx", {29'd0, out_idx}, 32'd5);
    end
    out_ready = 1'b1;
    wait_ready();
    chk("bp_count", log_q.size(), 32'd8);
    for (int k = 0; k < 8; k++) chk_log("bp_seq", k, k, (k == 7), 1'b0);

    // walking one, final shift is the empty vector
    for (int s = 0; s <= 8; s++) begin
      logic [WIDTH-1:0] w;
      w = 8'h01;
      w = w << s;
      run(w, 1'b0);
      chk("walk_count", log_q.size(), 32'd1);
      if (s < 8) chk_log("walk", 0, s, 1'b1, 1'b0);
      else       chk_log("walk_zero", 0, 0, 1'b1, 1'b1);
    end

    // reset mid-scan
    log_q.delete();
    send(8'hFF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_stale", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_beats", log_q.size(), 32'd1);

    // random vectors with random back-pressure, checked by the model
    for (int v = 0; v < 20; v++) begin
      send(8'($urandom), 1'($urandom));
      for (int k = 0; k < 200 && !in_ready; k++) begin
        out_ready = 1'($urandom);
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_ready();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
